// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requester ports, the single memory
// command/response port and the arbiter status outputs.
// slave  : the arbiter side (drives acks, memory command, status).
// master : the environment side (requesters and memory model).
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port memory with a
// fixed read latency of RD_LAT cycles (1..3).
// Sequence per access: IDLE (sample requests) -> ACCESS (one memory strobe)
// -> WAIT (reads only, RD_LAT cycles) -> DONE (one-cycle ack) -> IDLE.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   : tie-break pointer moves to the non-owner after every access.
//   undefined : tie-break pointer fixed at 0, requester 0 always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic clock,
  input  logic reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // WAIT counts down from RD_LAT-1; the cycle it reads zero is the last one.
  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t            state_r;
  state_t            state_s;

  logic              owner_r;
  logic              prio_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic [1:0]        cnt_r;

  logic              ack0_r;
  logic              ack1_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic              busy_r;

  logic              any_req_s;
  logic              win_s;
  logic              win_we_s;
  logic              ack0_s;
  logic              ack1_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic              busy_s;

  // Pick the winning requester and its write flag (only used in IDLE).
  always_comb begin
    any_req_s = bus.req0 | bus.req1;
    win_s     = 1'b0;
    win_we_s  = 1'b0;
    if (bus.req0 && bus.req1) begin
      win_s = prio_r;
    end else if (bus.req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (win_s) begin
      win_we_s = bus.we1;
    end else begin
      win_we_s = bus.we0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM output decode, evaluated on the next state so outputs can be registered.
  // ACCESS is only ever entered from IDLE, so its write flag is the winner's.
  always_comb begin
    ack0_s   = (state_s == DONE) && !owner_r;
    ack1_s   = (state_s == DONE) &&  owner_r;
    mem_en_s = (state_s == ACCESS);
    mem_we_s = (state_s == ACCESS) && win_we_s;
    busy_s   = (state_s != IDLE);
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      mem_en_r <= mem_en_s;
      mem_we_r <= mem_we_s;
      busy_r   <= busy_s;
    end
  end

  // Request latch, WAIT counter, read-data capture and tie-break pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      cnt_r   <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= win_s;
            we_r    <= win_we_s;
            addr_r  <= win_s ? bus.addr1  : bus.addr0;
            wdata_r <= win_s ? bus.wdata1 : bus.wdata0;
          end
        end
        ACCESS: begin
          cnt_r <= WAIT_LOAD;
        end
        WAIT: begin
          if (cnt_r == 2'd0) begin
            rdata_r <= bus.mem_rdata;
          end else begin
            cnt_r <= cnt_r - 2'd1;
          end
        end
        DONE: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          prio_r <= ~owner_r;
`else
          prio_r <= 1'b0;
`endif
        end
        default: begin
          cnt_r <= 2'd0;
        end
      endcase
    end
  end

  assign bus.ack0      = ack0_r;
  assign bus.ack1      = ack1_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.busy      = busy_r;
  assign bus.owner     = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. Two instances (RD_LAT=1 and RD_LAT=3) receive the
// same requester stimulus; each has its own memory stub and a transaction
// level model (operation length, owner, reference memory contents).
// Honours MEM_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [4:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit pick(input bit r0, input bit r1, input bit p);
    return (r0 && r1) ? p : r1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_lat
    localparam int LAT = (g == 0) ? 1 : 3;

    mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    assign bus.req0   = req0;
    assign bus.req1   = req1;
    assign bus.we0    = we0;
    assign bus.we1    = we1;
    assign bus.addr0  = addr0;
    assign bus.addr1  = addr1;
    assign bus.wdata0 = wdata0;
    assign bus.wdata1 = wdata1;

    mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(LAT)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    // Memory stub: writes on strobe, read data appears LAT cycles after strobe.
    logic [7:0] s_mem [32];
    logic [7:0] st1, st2, st3;
    bit         s_init = 1'b0;
    always @(posedge clk) begin
      if (!s_init) begin
        for (int i = 0; i < 32; i++) s_mem[i] <= 8'(i) ^ 8'h5A;
        s_init <= 1'b1;
      end
      if (bus.mem_en && bus.mem_we) s_mem[bus.mem_addr] <= bus.mem_wdata;
      st1 <= (bus.mem_en && !bus.mem_we) ? s_mem[bus.mem_addr] : 8'hEE;
      st2 <= st1;
      st3 <= st2;
    end
    assign bus.mem_rdata = (LAT == 1) ? st1 : st3;

    // Transaction model: an accepted op occupies positions 1..len after the
    // sampling cycle (len = 2 for writes, 2+LAT for reads); the ack sits at len.
    function automatic int op_len(input bit w);
      return w ? 2 : 2 + LAT;
    endfunction

    bit         m_act = 1'b0;
    int         m_pos = 0;
    bit         m_own = 1'b0;
    bit         m_we  = 1'b0;
    bit         m_prio = 1'b0;
    logic [4:0] m_addr;
    logic [7:0] m_wd, m_rd;
    logic [7:0] m_mem [32];
    bit         m_init = 1'b0;

    always @(posedge clk) begin
      if (!m_init) begin
        for (int i = 0; i < 32; i++) m_mem[i] <= 8'(i) ^ 8'h5A;
        m_init <= 1'b1;
      end
      if (reset) begin
        m_act <= 1'b0; m_pos <= 0; m_own <= 1'b0; m_prio <= 1'b0;
        m_addr <= 5'd0; m_wd <= 8'd0; m_rd <= 8'd0;
      end else if (!m_act) begin
        if (req0 || req1) begin
          m_act  <= 1'b1;
          m_pos  <= 1;
          m_own  <= pick(req0, req1, m_prio);
          m_we   <= pick(req0, req1, m_prio) ? we1 : we0;
          m_addr <= pick(req0, req1, m_prio) ? addr1 : addr0;
          m_wd   <= pick(req0, req1, m_prio) ? wdata1 : wdata0;
          if (pick(req0, req1, m_prio) ? we1 : we0)
            m_mem[pick(req0, req1, m_prio) ? addr1 : addr0] <= pick(req0, req1, m_prio) ? wdata1 : wdata0;
        end
      end else if (m_pos == op_len(m_we)) begin
        m_act <= 1'b0;
        m_pos <= 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        m_prio <= ~m_own;
`endif
      end else begin
        m_pos <= m_pos + 1;
        if (!m_we && (m_pos + 1 == op_len(m_we))) m_rd <= m_mem[m_addr];
      end
    end

    logic e_done;
    assign e_done = m_act && (m_pos == op_len(m_we));

    // Compare every DUT output with the model in the middle of each cycle.
    always @(negedge clk) begin
      if (chk_on) begin
        chk($sformatf("lat%0d.ack0", LAT),      32'(bus.ack0),      32'(e_done && !m_own));
        chk($sformatf("lat%0d.ack1", LAT),      32'(bus.ack1),      32'(e_done && m_own));
        chk($sformatf("lat%0d.busy", LAT),      32'(bus.busy),      32'(m_act));
        chk($sformatf("lat%0d.owner", LAT),     32'(bus.owner),     32'(m_own));
        chk($sformatf("lat%0d.mem_en", LAT),    32'(bus.mem_en),    32'(m_act && m_pos == 1));
        chk($sformatf("lat%0d.mem_we", LAT),    32'(bus.mem_we),    32'(m_act && m_pos == 1 && m_we));
        chk($sformatf("lat%0d.mem_addr", LAT),  32'(bus.mem_addr),  32'(m_addr));
        chk($sformatf("lat%0d.mem_wdata", LAT), 32'(bus.mem_wdata), 32'(m_wd));
        chk($sformatf("lat%0d.rdata", LAT),     32'(bus.rdata),     32'(m_rd));
        chk($sformatf("lat%0d.one_ack", LAT),   32'(bus.ack0 & bus.ack1), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input bit r0, input bit r1, input bit w0, input bit w1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    tick();
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (7) tick();
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 5'd0; addr1 = 5'd0; wdata0 = 8'd0; wdata1 = 8'd0;

    // Reset state.
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy",  32'(gen_lat[0].bus.busy),     32'd0);
    chk("rst_rdata", 32'(gen_lat[0].bus.rdata),    32'd0);
    chk("rst_addr",  32'(gen_lat[0].bus.mem_addr), 32'd0);
    tick();
    reset = 1'b0;

    // Write from requester 0.
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 8'hA5;
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("wr_mem_en",    32'(gen_lat[0].bus.mem_en),    32'd1);
    chk("wr_mem_we",    32'(gen_lat[0].bus.mem_we),    32'd1);
    chk("wr_mem_addr",  32'(gen_lat[0].bus.mem_addr),  32'd5);
    chk("wr_mem_wdata", 32'(gen_lat[0].bus.mem_wdata), 32'hA5);
    tick();
    @(negedge clk);
    chk("wr_ack0_l1", 32'(gen_lat[0].bus.ack0), 32'd1);
    chk("wr_ack0_l3", 32'(gen_lat[1].bus.ack0), 32'd1);
    repeat (3) tick();

    // Read back from requester 1.
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd5;
    tick();
    req1 = 1'b0;
    @(negedge clk);
    chk("rd_mem_en", 32'(gen_lat[0].bus.mem_en), 32'd1);
    chk("rd_mem_we", 32'(gen_lat[0].bus.mem_we), 32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("rd_ack1_l1",  32'(gen_lat[0].bus.ack1),  32'd1);
    chk("rd_data_l1",  32'(gen_lat[0].bus.rdata), 32'hA5);
    chk("rd_early_l3", 32'(gen_lat[1].bus.ack1),  32'd0);
    tick();
    tick();
    @(negedge clk);
    chk("rd_ack1_l3", 32'(gen_lat[1].bus.ack1),  32'd1);
    chk("rd_data_l3", 32'(gen_lat[1].bus.rdata), 32'hA5);
    repeat (3) tick();

    // Directed patterns, including ties.
    issue(1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  5'd31, 8'h00, 8'h3C);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 5'd0,  8'h00, 8'h00);
    chk("rd31_l1", 32'(gen_lat[0].bus.rdata), 32'h3C);
    chk("rd31_l3", 32'(gen_lat[1].bus.rdata), 32'h3C);
    issue(1'b1, 1'b1, 1'b1, 1'b0, 5'd2,  5'd0,  8'h11, 8'h00);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie1_rdata", 32'(gen_lat[0].bus.rdata), 32'h5A);
`else
    chk("tie1_rdata", 32'(gen_lat[0].bus.rdata), 32'h3C);
`endif
    issue(1'b1, 1'b1, 1'b0, 1'b1, 5'd2,  5'd6,  8'h00, 8'h66);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("tie2_rdata", 32'(gen_lat[1].bus.rdata), 32'h58);
`else
    chk("tie2_rdata", 32'(gen_lat[1].bus.rdata), 32'h11);
`endif

    // Reset in the middle of a read.
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd31;
    tick();
    req0 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 1; g++) begin
      chk("mid_busy_l1",   32'(gen_lat[0].bus.busy),   32'd0);
      chk("mid_en_l1",     32'(gen_lat[0].bus.mem_en), 32'd0);
      chk("mid_rdata_l1",  32'(gen_lat[0].bus.rdata),  32'd0);
      chk("mid_busy_l3",   32'(gen_lat[1].bus.busy),   32'd0);
      chk("mid_rdata_l3",  32'(gen_lat[1].bus.rdata),  32'd0);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      chk("mid_noack_l1", 32'(gen_lat[0].bus.ack0), 32'd0);
      chk("mid_noack_l3", 32'(gen_lat[1].bus.ack0), 32'd0);
    end

    // Request raised while busy is served after the current ack.
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 5'd7; wdata0 = 8'h77;
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 5'd7;
    tick();
    @(negedge clk);
    chk("ign_ack0_l1", 32'(gen_lat[0].bus.ack0), 32'd1);
    chk("ign_ack0_l3", 32'(gen_lat[1].bus.ack0), 32'd1);
    tick();
    tick();
    req1 = 1'b0; we1 = 1'b1; addr1 = 5'd9;
    for (int c = 4; c <= 9; c++) begin
      @(negedge clk);
      chk("ign_ack1_l1", 32'(gen_lat[0].bus.ack1), 32'(c == 6));
      chk("ign_ack1_l3", 32'(gen_lat[1].bus.ack1), 32'(c == 8));
      tick();
    end
    chk("ign_rdata_l3", 32'(gen_lat[1].bus.rdata), 32'h77);

    // Contention from reset release, both requesters writing.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 5'd3; addr1 = 5'd4; wdata0 = 8'h33; wdata1 = 8'h44;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c % 3 == 2) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("cont_ack0", 32'(gen_lat[0].bus.ack0), 32'(((c - 2) / 3) % 2 == 0));
        chk("cont_ack1", 32'(gen_lat[0].bus.ack1), 32'(((c - 2) / 3) % 2 == 1));
`else
        chk("cont_ack0", 32'(gen_lat[0].bus.ack0), 32'd1);
        chk("cont_ack1", 32'(gen_lat[0].bus.ack1), 32'd0);
`endif
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
